// File: rtl/hv_memory_array.sv
// Banked hypervector table store: a word-serial loader assembles one row and commits it in a
// single cycle, and a one-cycle-latency read port returns one row from every table at once.
module hv_memory_array #(
  parameter int unsigned HV_DIM     = 2000,
  parameter int unsigned NUM_TABLES = 3,
  parameter int unsigned DEPTH      = 80,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned BANK_W     = 144,
  parameter int unsigned LOAD_W     = 32,
  localparam int unsigned TBL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rd_req_i,
  output logic                         rd_ready_o,
  input  logic [NUM_TABLES*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_TABLES*HV_DIM-1:0] rd_dout_o,
  output logic                         rd_valid_o,
  input  logic                         ld_valid_i,
  output logic                         ld_ready_o,
  input  logic [TBL_W-1:0]             ld_table_i,
  input  logic [ADDR_W-1:0]            ld_addr_i,
  input  logic [LOAD_W-1:0]            ld_data_i,
  output logic                         ld_done_o,
  output logic                         err_o
);

  localparam int unsigned NBANK  = (HV_DIM + BANK_W - 1) / BANK_W;
  localparam int unsigned NCHUNK = (HV_DIM + LOAD_W - 1) / LOAD_W;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {StIdle, StFill, StCommit} ld_state_e;

  ld_state_e             state_q, state_d;
  logic [CNT_W-1:0]      chunk_q, chunk_d;
  logic [TBL_W-1:0]      tbl_q, tbl_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [HV_DIM-1:0]     row_q, row_d;
  logic                  err_q, err_d;
  logic                  rd_valid_q;
  logic                  ld_fire, rd_fire, commit, wr_ok;
  logic [NUM_TABLES-1:0] rd_bad;

  // The commit cycle owns the banks, so reads are held off for exactly that cycle.
  assign commit     = (state_q == StCommit);
  assign ld_ready_o = ~commit;
  assign rd_ready_o = ~commit;
  assign ld_fire    = ld_valid_i & ld_ready_o;
  assign rd_fire    = rd_req_i & rd_ready_o;
  assign wr_ok      = commit && (32'(tbl_q) < NUM_TABLES) && (32'(addr_q) < DEPTH);
  assign ld_done_o  = commit;
  assign rd_valid_o = rd_valid_q;
  assign err_o      = err_q;

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    tbl_d   = tbl_q;
    addr_d  = addr_q;
    row_d   = row_q;
    err_d   = err_q | (rd_fire & (|rd_bad));
    case (state_q)
      StIdle, StFill: begin
        if (ld_fire) begin
          if (state_q == StIdle) begin
            tbl_d  = ld_table_i;
            addr_d = ld_addr_i;
          end
          // Bits of the last word that land at or above HV_DIM have no home and are dropped.
          for (int i = 0; i < HV_DIM; i++) begin
            if (i / LOAD_W == int'(chunk_q)) row_d[i] = ld_data_i[i % LOAD_W];
          end
          chunk_d = chunk_q + CNT_W'(1);
          state_d = (32'(chunk_q) == NCHUNK - 1) ? StCommit : StFill;
        end
      end
      StCommit: begin
        state_d = StIdle;
        chunk_d = '0;
        if (!wr_ok) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      chunk_q    <= '0;
      tbl_q      <= '0;
      addr_q     <= '0;
      row_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chunk_q    <= chunk_d;
      tbl_q      <= tbl_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      err_q      <= err_d;
      rd_valid_q <= rd_fire;
    end
  end

  for (genvar t = 0; t < NUM_TABLES; t++) begin : g_tbl
    logic [ADDR_W-1:0] rd_addr;

    assign rd_addr   = rd_addr_i[t*ADDR_W +: ADDR_W];
    assign rd_bad[t] = (32'(rd_addr) >= DEPTH);

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
      localparam int unsigned Lo = b * BANK_W;
      localparam int unsigned Bw = (b == NBANK - 1) ? HV_DIM - Lo : BANK_W;

      logic [Bw-1:0] mem_q [DEPTH];
      logic [Bw-1:0] dout_q;

      // Storage is deliberately left unreset.
      always_ff @(posedge clk_i) begin
        if (wr_ok && (32'(tbl_q) == 32'(t))) mem_q[addr_q] <= row_q[Lo +: Bw];
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          dout_q <= '0;
        end else if (rd_fire) begin
          dout_q <= rd_bad[t] ? '0 : mem_q[rd_addr];
        end
      end

      assign rd_dout_o[t*HV_DIM + Lo +: Bw] = dout_q;
    end
  end

endmodule

// File: tb/tb_hv_memory_array.sv
// Randomized bench for hv_memory_array: loads and reads are scored against an array-of-rows model.
module tb_hv_memory_array;

  localparam int unsigned HV_DIM = 2000;
  localparam int unsigned NT     = 3;
  localparam int unsigned DEPTH  = 80;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned LOAD_W = 32;
  localparam int unsigned TBL_W  = 2;
  localparam int unsigned NCHUNK = (HV_DIM + LOAD_W - 1) / LOAD_W;
  localparam int unsigned PADW   = ((HV_DIM + 63) / 64) * 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   rd_req, rd_ready, rd_valid;
  logic [NT*ADDR_W-1:0]   rd_addr;
  logic [NT*HV_DIM-1:0]   rd_dout;
  logic                   ld_valid, ld_ready, ld_done, err;
  logic [TBL_W-1:0]       ld_table;
  logic [ADDR_W-1:0]      ld_addr;
  logic [LOAD_W-1:0]      ld_data;

  hv_memory_array #(
    .HV_DIM    (HV_DIM),
    .NUM_TABLES(NT),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BANK_W    (144),
    .LOAD_W    (LOAD_W)
  ) u_dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_req_i  (rd_req),
    .rd_ready_o(rd_ready),
    .rd_addr_i (rd_addr),
    .rd_dout_o (rd_dout),
    .rd_valid_o(rd_valid),
    .ld_valid_i(ld_valid),
    .ld_ready_o(ld_ready),
    .ld_table_i(ld_table),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data),
    .ld_done_o (ld_done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  logic [HV_DIM-1:0]    ref_mem [NT][DEPTH];
  logic [NT*HV_DIM-1:0] exp_dout;
  logic [NT*ADDR_W-1:0] dir_addr;
  int                   n_checks = 0;
  int                   n_errors = 0;
  int                   rd_mode  = 0;
  int                   done_cnt = 0;
  int                   done_exp = 0;
  bit                   chk_on   = 1'b0;
  bit                   pend     = 1'b0;
  bit                   dir_go   = 1'b0;
  bit                   commit_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reports the lowest differing 64-bit word of each table slice (or word 0 when all agree).
  task automatic check_dout();
    for (int t = 0; t < NT; t++) begin
      logic [PADW-1:0] o, e;
      int w;
      o = PADW'(rd_dout[t*HV_DIM +: HV_DIM]);
      e = PADW'(exp_dout[t*HV_DIM +: HV_DIM]);
      w = 0;
      for (int i = PADW / 64 - 1; i >= 0; i--) begin
        if (o[i*64 +: 64] !== e[i*64 +: 64]) w = i;
      end
      check($sformatf("rd_dout_t%0d_w%0d", t, w), o[w*64 +: 64], e[w*64 +: 64]);
    end
  endtask

  function automatic logic [NT*HV_DIM-1:0] expect_read(input logic [NT*ADDR_W-1:0] a);
    logic [NT*HV_DIM-1:0] e;
    for (int t = 0; t < NT; t++) begin
      int r;
      r = int'(a[t*ADDR_W +: ADDR_W]);
      e[t*HV_DIM +: HV_DIM] = (r < int'(DEPTH)) ? ref_mem[t][r] : '0;
    end
    return e;
  endfunction

  function automatic logic [NT*ADDR_W-1:0] rand_addr();
    logic [NT*ADDR_W-1:0] a;
    for (int t = 0; t < NT; t++) a[t*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, DEPTH - 1));
    return a;
  endfunction

  always @(negedge clk) if (ld_done) done_cnt++;

  // Read master + scoreboard: one outstanding expectation, checked one cycle after acceptance.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("rd_valid", 64'(rd_valid), 64'(pend));
      check_dout();
      check("rd_ready", 64'(rd_ready), 64'(!commit_exp));
    end
    pend   = 1'b0;
    rd_req = 1'b0;
    if (!rst) begin
      case (rd_mode)
        1: begin rd_req = 1'($urandom_range(0, 1)); rd_addr = rand_addr(); end
        2: begin rd_req = 1'b1; rd_addr = rand_addr(); end
        3: if (dir_go) begin rd_req = 1'b1; rd_addr = dir_addr; end
        4: begin rd_req = 1'b1; rd_addr = dir_addr; end
        default: ;
      endcase
      if (rd_req && rd_ready) begin
        pend     = 1'b1;
        exp_dout = expect_read(rd_addr);
        if (rd_mode == 3) dir_go = 1'b0;
      end
    end
  end

  task automatic set_mode(input int m);
    @(posedge clk);
    #1;
    rd_mode = m;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_row(input int tbl, input int addr, input int nsend, input bit throttle,
                          input bit ramp);
    logic [LOAD_W-1:0]        words [$];
    logic [NCHUNK*LOAD_W-1:0] full;
    int k, cyc, done0;
    bit rdy;
    k = 0;
    cyc = 0;
    done0 = done_cnt;
    while (k < nsend && cyc < 4 * int'(NCHUNK) + 10) begin
      @(negedge clk);
      if (words.size() == k) words.push_back(ramp ? LOAD_W'(k) : LOAD_W'($urandom()));
      ld_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      ld_table = (k == 0) ? TBL_W'(tbl) : TBL_W'($urandom());
      ld_addr  = (k == 0) ? ADDR_W'(addr) : ADDR_W'($urandom());
      ld_data  = words[k];
      rdy      = ld_ready;
      check("ld_ready_fill", 64'(rdy), 64'(1));
      @(posedge clk);
      if (ld_valid && rdy) begin
        k++;
        if (k == int'(NCHUNK)) commit_exp = 1'b1;
      end
      cyc++;
    end
    if (k < nsend) check("ld_timeout", 64'(k), 64'(nsend));
    @(negedge clk);
    ld_valid = 1'b0;
    if (k == int'(NCHUNK)) begin
      check("ld_done_commit", 64'(ld_done), 64'(1));
      check("ld_ready_commit", 64'(ld_ready), 64'(0));
      if (tbl < int'(NT) && addr < int'(DEPTH)) begin
        full = '0;
        for (int i = 0; i < int'(NCHUNK); i++) full[i*LOAD_W +: LOAD_W] = words[i];
        ref_mem[tbl][addr] = full[HV_DIM-1:0];
      end
      @(posedge clk);
      #1;
      commit_exp = 1'b0;
      done_exp++;
      check("ld_done_count", 64'(done_cnt), 64'(done0 + 1));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    chk_on   = 1'b0;
    rd_mode  = 0;
    rst      = 1'b1;
    pend     = 1'b0;
    exp_dout = '0;
    ld_valid = 1'b0;
    wait_cycles(2);
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_ld_done", 64'(ld_done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_ld_ready", 64'(ld_ready), 64'(1));
    check("rst_rd_ready", 64'(rd_ready), 64'(1));
    check_dout();
    rst = 1'b0;
    #1;
    chk_on = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    rd_req   = 1'b0;
    rd_addr  = '0;
    ld_valid = 1'b0;
    ld_table = '0;
    ld_addr  = '0;
    ld_data  = '0;
    exp_dout = '0;
    dir_addr = '0;
    do_reset();

    // Give every row known contents so any random read can be scored.
    for (int t = 0; t < int'(NT); t++) begin
      for (int r = 0; r < int'(DEPTH); r++) load_row(t, r, NCHUNK, 1'b0, 1'b0);
    end

    // Ramp load to table 1 row 5 with background reads, then a directed read.
    set_mode(1);
    load_row(1, 5, NCHUNK, 1'b0, 1'b1);
    dir_addr = rand_addr();
    dir_addr[ADDR_W +: ADDR_W] = ADDR_W'(5);
    dir_go = 1'b1;
    rd_mode = 3;
    wait_cycles(4);
    check("t1r5_low_word", 64'(rd_dout[HV_DIM +: 32]), 64'(0));
    check("t1r5_top_bits", 64'(rd_dout[HV_DIM + 1984 +: 16]), 64'(16'h003E));

    // Read the row being loaded on every cycle, including the one right after commit.
    for (int t = 0; t < int'(NT); t++) dir_addr[t*ADDR_W +: ADDR_W] = ADDR_W'(79);
    set_mode(4);
    load_row(0, 79, NCHUNK, 1'b0, 1'b0);
    wait_cycles(2);
    check("t0r79_new", rd_dout[63:0], ref_mem[0][79][63:0]);

    // Continuous reads while loading, back-to-back and throttled.
    set_mode(2);
    load_row(2, int'($urandom_range(0, DEPTH - 1)), NCHUNK, 1'b0, 1'b0);
    load_row(0, int'($urandom_range(0, DEPTH - 1)), NCHUNK, 1'b1, 1'b0);

    // Throttled ramp load must keep word order.
    set_mode(1);
    load_row(1, 40, NCHUNK, 1'b1, 1'b1);
    for (int t = 0; t < int'(NT); t++) dir_addr[t*ADDR_W +: ADDR_W] = ADDR_W'(40);
    set_mode(4);
    wait_cycles(3);
    check("t1r40_word10", 64'(rd_dout[HV_DIM + 10*32 +: 32]), 64'(10));
    check("no_err_yet", 64'(err), 64'(0));

    // Reset in the middle of a fill abandons the row.
    set_mode(0);
    load_row(0, 10, 30, 1'b0, 1'b0);
    do_reset();
    for (int t = 0; t < int'(NT); t++) dir_addr[t*ADDR_W +: ADDR_W] = ADDR_W'(10);
    set_mode(4);
    wait_cycles(3);
    set_mode(0);
    load_row(0, 11, NCHUNK, 1'b0, 1'b0);
    for (int t = 0; t < int'(NT); t++) dir_addr[t*ADDR_W +: ADDR_W] = ADDR_W'(11);
    set_mode(4);
    wait_cycles(3);

    // Out-of-range row address: no write, sticky error.
    set_mode(0);
    load_row(2, 80, NCHUNK, 1'b0, 1'b0);
    check("err_bad_row", 64'(err), 64'(1));
    dir_addr = '0;
    set_mode(4);
    wait_cycles(3);
    check("err_sticky", 64'(err), 64'(1));

    // Out-of-range table index.
    do_reset();
    load_row(3, 0, NCHUNK, 1'b0, 1'b0);
    check("err_bad_table", 64'(err), 64'(1));
    dir_addr = '0;
    set_mode(4);
    wait_cycles(3);

    // Out-of-range read address on table 0 only.
    do_reset();
    check("err_cleared", 64'(err), 64'(0));
    dir_addr = {ADDR_W'(3), ADDR_W'(2), ADDR_W'(100)};
    dir_go = 1'b1;
    rd_mode = 3;
    wait_cycles(4);
    check("bad_rd_zero", rd_dout[63:0], 64'(0));
    check("err_bad_read", 64'(err), 64'(1));

    set_mode(0);
    wait_cycles(2);
    check("done_total", 64'(done_cnt), 64'(done_exp));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hv_memory_array.md
HV_MEMORY_ARRAY -- requirements
Module: hv_memory_array

Interface
REQ-001 SHALL have parameter HV_DIM, default 2000: hypervector width in bits.
REQ-002 SHALL have parameter NUM_TABLES, default 3: independent HV tables (IM, ProjM-pos, ProjM-neg).
REQ-003 SHALL have parameter DEPTH, default 80: rows per table.
REQ-004 SHALL have parameter ADDR_W, default 7: row address width, with 2^ADDR_W >= DEPTH.
REQ-005 SHALL have parameter BANK_W, default 144: storage bank width, with NBANK = ceil(HV_DIM/BANK_W) and the last bank HV_DIM-(NBANK-1)*BANK_W wide.
REQ-006 SHALL have parameter LOAD_W, default 32: load bus width, with NCHUNK = ceil(HV_DIM/LOAD_W).
REQ-007 Ports SHALL be: clk in 1 clock; rst in 1 asynchronous active-high reset.
REQ-008 Ports SHALL include: rd_req in 1, read request for all tables; rd_ready out 1, read accepted when high with rd_req; rd_addr in NUM_TABLES*ADDR_W, per-table row address, table t in slice t.
REQ-009 Ports SHALL include: rd_dout out NUM_TABLES*HV_DIM, per-table row data, table t in slice t; rd_valid out 1, rd_dout valid.
REQ-010 Ports SHALL include: ld_valid in 1; ld_ready out 1; ld_table in clog2(NUM_TABLES); ld_addr in ADDR_W; ld_data in LOAD_W.
REQ-011 Ports SHALL include: ld_done out 1, one-cycle pulse when a row is committed; err out 1, sticky address/table error.

Function
REQ-012 Storage SHALL be NUM_TABLES x NBANK banks of DEPTH rows each; contents SHALL NOT be reset.
REQ-013 Read: an accepted read (rd_req & rd_ready) in cycle N SHALL drive rd_valid=1 in cycle N+1, with rd_dout holding each table's row at its own rd_addr slice.
REQ-014 rd_valid SHALL be 0 in any cycle that follows a cycle without an accepted read; rd_dout SHALL hold its last value while rd_valid=0.
REQ-015 Loader FSM SHALL have states IDLE, FILL, COMMIT.
REQ-016 In IDLE, ld_ready SHALL be 1. The first accepted word SHALL latch ld_table and ld_addr, store the word, set chunk count to 1 and go to FILL, or straight to COMMIT if NCHUNK=1.
REQ-017 In FILL, ld_ready SHALL be 1. Accepted word k (0-based) SHALL fill row buffer bits [k*LOAD_W +: LOAD_W]; bits at or above HV_DIM SHALL be discarded. ld_table and ld_addr SHALL be ignored after word 0.
REQ-018 After word NCHUNK-1 is accepted, the FSM SHALL enter COMMIT, with ld_ready=0 for that cycle.
REQ-019 COMMIT SHALL last exactly one cycle. It SHALL write the full row buffer to all NBANK banks of the latched table at the latched address, pulse ld_done=1, and return to IDLE.
REQ-020 If the latched address is >= DEPTH or the table is >= NUM_TABLES, COMMIT SHALL NOT write. It SHALL set err=1, still pulse ld_done, and return to IDLE.
REQ-021 rd_ready SHALL be 0 during COMMIT (write priority) and 1 in all other states. A rd_req during COMMIT SHALL be held off, not dropped, by the master.
REQ-022 A read to the row currently being committed SHALL be impossible by REQ-021. A read accepted the cycle after COMMIT SHALL return the newly written data.
REQ-023 Reads SHALL be accepted concurrently with IDLE/FILL loading without affecting the loader.
REQ-024 A read address >= DEPTH SHALL return all-zero data on that table's slice and set err=1.
REQ-025 err SHALL clear only on rst.

Reset
REQ-026 rst=1 SHALL asynchronously force: FSM to IDLE, chunk count 0, rd_valid=0, ld_done=0, err=0, rd_dout=0, row buffer=0.
REQ-027 After rst deasserts, ld_ready=1 and rd_ready=1. Reset mid-FILL SHALL abandon the partial row with no memory write.

Verification
REQ-028 Load table 1 row 5 with 63 words 0x00000000..0x0000003E, then read with rd_addr slice1=5 -> rd_valid one cycle after accept; slice1 bits [31:0]=0, bits [1999:1984]=0x003E low 16 bits; ld_done pulses once.
REQ-029 Load table 0 row 79, then read row 79 the cycle after ld_done -> new data returned, no stale value.
REQ-030 Assert rd_req continuously while loading -> rd_ready=0 only in the COMMIT cycle; all other reads complete with 1-cycle latency.
REQ-031 Load table 2 with ld_addr=80 -> no write, err=1 after COMMIT; row 0 of table 2 unchanged.
REQ-032 Assert rst after 30 of 63 words -> FSM IDLE, err=0, rd_valid=0; later read of the target row returns its pre-load contents.
REQ-033 Throttle ld_valid randomly (0/1 alternating) -> row assembled identically to back-to-back loading; word order preserved.
